// File: rtl/tadd_pkg.sv
// tadd_pkg: shared defaults, checker FSM states and the err_count saturation limit.
package tadd_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_LANES = 4;
  localparam logic [15:0] ERR_SAT = 16'hFFFF;
  typedef enum logic [1:0] {PRIME, CHECK, DONE} state_t;
endpackage

// File: rtl/tadd_ref_model.sv
// tadd_ref_model: enabled LATENCY-stage delay line of wrapping per-lane a+b sums.
module tadd_ref_model #(
  parameter int WIDTH = 8,
  parameter int LANES = 4,
  parameter int LATENCY = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   en,
  input  logic [LANES*WIDTH-1:0] a,
  input  logic [LANES*WIDTH-1:0] b,
  output logic [LANES*WIDTH-1:0] y
);
  logic [LANES*WIDTH-1:0] sum;
  logic [LANES*WIDTH-1:0] stage [LATENCY];
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign sum[i*WIDTH +: WIDTH] = a[i*WIDTH +: WIDTH] + b[i*WIDTH +: WIDTH];
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < LATENCY; k++) stage[k] <= '0;
    end else if (en) begin
      stage[0] <= sum;
      for (int k = 1; k < LATENCY; k++) stage[k] <= stage[k-1];
    end
  end
  assign y = stage[LATENCY-1];
endmodule

// File: rtl/tadd_checker.sv
// tadd_checker: primes, compares y to the reference for NUM_CHECKS edges, then latches a verdict; TADD_CHECKER_DISPLAY_EN adds mismatch/summary prints.
module tadd_checker
  import tadd_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LANES = DEF_LANES,
  parameter int LATENCY = 1,
  parameter int NUM_CHECKS = 10
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   en,
  input  logic [LANES*WIDTH-1:0] a,
  input  logic [LANES*WIDTH-1:0] b,
  input  logic [LANES*WIDTH-1:0] y,
  input  logic [31:0]            cycles,
  output logic [LANES-1:0]       mismatch,
  output logic [15:0]            err_count,
  output logic [31:0]            first_err_cycle,
  output logic                   done,
  output logic                   pass
);
  state_t state;
  logic [3:0] prime_cnt;
  logic [31:0] chk_cnt;
  logic [LANES*WIDTH-1:0] exp_y;
  logic [LANES-1:0] mm;
  logic last;
  tadd_ref_model #(.WIDTH(WIDTH), .LANES(LANES), .LATENCY(LATENCY)) u_ref (
    .clock(clock), .reset(reset), .en(en), .a(a), .b(b), .y(exp_y)
  );
  for (genvar i = 0; i < LANES; i++) begin : g_cmp
    assign mm[i] = y[i*WIDTH +: WIDTH] != exp_y[i*WIDTH +: WIDTH];
  end
  assign last = chk_cnt == 32'(NUM_CHECKS - 1);
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= PRIME;
      prime_cnt <= '0;
      chk_cnt <= '0;
      mismatch <= '0;
      err_count <= '0;
      first_err_cycle <= '0;
      done <= 1'b0;
      pass <= 1'b0;
    end else if (state == PRIME) begin
      if (en) begin
        prime_cnt <= prime_cnt + 4'd1;
        if (prime_cnt == 4'(LATENCY - 1)) state <= CHECK;
      end
    end else if (state == CHECK) begin
      mismatch <= mm;
      chk_cnt <= chk_cnt + 32'd1;
      if (|mm) begin
        err_count <= (err_count == ERR_SAT) ? err_count : err_count + 16'd1;
        if (err_count == '0) first_err_cycle <= cycles;
      end
      if (last) begin
        state <= DONE;
        done <= 1'b1;
        pass <= ~|mm && err_count == '0;
      end
    end
  end
`ifdef TADD_CHECKER_DISPLAY_EN
  always @(posedge clock) begin
    if (!reset && state == CHECK) begin
      for (int i = 0; i < LANES; i++)
        if (mm[i])
          $display("tadd_checker: cycle %0d lane %0d expected %0d actual %0d", cycles, i,
                   $signed(exp_y[i*WIDTH +: WIDTH]), $signed(y[i*WIDTH +: WIDTH]));
      if (last)
        $display("tadd_checker: %s after %0d checks", (~|mm && err_count == '0) ? "PASS" : "FAIL",
                 NUM_CHECKS);
    end
  end
`endif
endmodule

// File: tb/tb_tadd_checker.sv
// tb_tadd_checker: drives two checkers (LATENCY 1 and 2) from a bench-side ideal DUT with injected faults.
module tb_tadd_checker;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset, en;
  logic [31:0] a, b, y0, y1, cycles;
  logic [3:0] mm0, mm1;
  logic [15:0] ec0, ec1;
  logic [31:0] fe0, fe1;
  logic d0, d1, p0, p1;
  tadd_checker #(.LATENCY(1), .NUM_CHECKS(10)) u0 (
    .clock(clk), .reset(reset), .en(en), .a(a), .b(b), .y(y0), .cycles(cycles),
    .mismatch(mm0), .err_count(ec0), .first_err_cycle(fe0), .done(d0), .pass(p0)
  );
  tadd_checker #(.LATENCY(2), .NUM_CHECKS(10)) u1 (
    .clock(clk), .reset(reset), .en(en), .a(a), .b(b), .y(y1), .cycles(cycles),
    .mismatch(mm1), .err_count(ec1), .first_err_cycle(fe1), .done(d1), .pass(p1)
  );
  int passed = 0, total = 0, cyc = 0;
  logic [31:0] hist [$];
  int lat [2] = '{1, 2};
  int nen [2], ncmp [2];
  logic [3:0] emm [2];
  logic [15:0] eec [2];
  logic [31:0] efe [2];
  logic ed [2], ep [2];
  logic [31:0] A = 32'h07081CFD, B = 32'h030F0108;
  function automatic logic [31:0] ideal(int l);
    return hist.size() >= l ? hist[hist.size()-l] : 32'h0;
  endfunction
  function automatic logic [31:0] lanesum(logic [31:0] x, logic [31:0] z);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[i*8 +: 8] = 8'((x[i*8 +: 8] + z[i*8 +: 8]) % 256);
    return r;
  endfunction
  function automatic logic [31:0] inject(logic [31:0] v, logic [3:0] f);
    for (int i = 0; i < 4; i++) if (f[i]) v[i*8 +: 8] = v[i*8 +: 8] ^ 8'h0F;
    return v;
  endfunction
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask
  task automatic model_edge(int j, logic r, logic e, logic [31:0] yv, logic [31:0] cv);
    logic [31:0] x;
    logic [3:0] m;
    if (r) begin
      nen[j] = 0; ncmp[j] = 0; emm[j] = 0; eec[j] = 0; efe[j] = 0; ed[j] = 0; ep[j] = 0;
    end else if (!ed[j] && nen[j] >= lat[j]) begin
      x = ideal(lat[j]);
      for (int i = 0; i < 4; i++) m[i] = yv[i*8 +: 8] != x[i*8 +: 8];
      emm[j] = m;
      if (m != 0) begin
        if (eec[j] == 0) efe[j] = cv;
        if (eec[j] != 16'hFFFF) eec[j]++;
      end
      ncmp[j]++;
      if (ncmp[j] == 10) begin
        ed[j] = 1;
        ep[j] = eec[j] == 0;
      end
    end else if (!ed[j] && e) nen[j]++;
  endtask
  task automatic step(logic r, logic e, logic [31:0] av, logic [31:0] bv, logic [3:0] f0, logic [3:0] f1);
    @(negedge clk);
    reset = r; en = e; a = av; b = bv; cycles = cyc;
    y0 = inject(ideal(1), f0);
    y1 = inject(ideal(2), f1);
    @(posedge clk);
    #1;
    model_edge(0, r, e, y0, cycles);
    model_edge(1, r, e, y1, cycles);
    if (r) hist.delete();
    else if (e) hist.push_back(lanesum(av, bv));
    cyc = r ? 0 : cyc + 1;
    chk("mismatch0", mm0, emm[0]); chk("err_count0", ec0, eec[0]); chk("first_err0", fe0, efe[0]);
    chk("done0", d0, ed[0]); chk("pass0", p0, ep[0]);
    chk("mismatch1", mm1, emm[1]); chk("err_count1", ec1, eec[1]); chk("first_err1", fe1, efe[1]);
    chk("done1", d1, ed[1]); chk("pass1", p1, ep[1]);
  endtask
  initial begin
    reset = 1; en = 0; a = 0; b = 0; y0 = 0; y1 = 0; cycles = 0;
    step(1, 0, 0, 0, 0, 0);
    step(1, 1, A, B, 0, 0);
    for (int k = 0; k < 14; k++) begin
      step(0, 1, A, B, 0, 0);
      if (k == 9) chk("done_at_11_edges", d0, 1'b0);
      if (k == 10) chk("done_at_11_edges", d0, 1'b1);
    end
    chk("correct_pass", p0, 1'b1);
    step(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 14; k++) begin
      step(0, 1, A, B, cyc == 5 ? 4'b0100 : 4'b0000, 0);
      if (k == 5) chk("single_fault_mm", mm0, 4'b0100);
      if (k == 6) chk("single_fault_clear", mm0, 4'b0000);
    end
    chk("fault_count", ec0, 16'd1); chk("fault_cycle", fe0, 32'd5); chk("fault_pass", p0, 1'b0);
    step(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 14; k++) step(0, 1, {$urandom_range(0, 16777215), 8'hFF}, 32'h00000001, 0, 0);
    chk("wrap_pass", p0, 1'b1); chk("wrap_pass_l2", p1, 1'b1);
    step(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 16; k++) step(0, !(k >= 5 && k <= 7), $urandom, $urandom, 0, 0);
    chk("gap_done", d1, 1'b1); chk("gap_pass", p1, 1'b1);
    step(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) step(0, 1, $urandom, $urandom, (cyc == 2 || cyc == 3) ? 4'b1001 : 4'b0000, 4'b0000);
    chk("pre_reset_errs", ec0, 16'd2);
    step(1, 1, $urandom, $urandom, 0, 0);
    chk("mid_reset_errs", ec0, 16'd0);
    for (int k = 0; k < 14; k++) step(0, 1, $urandom, $urandom, 0, 0);
    chk("rerun_pass", p0, 1'b1);
    step(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 10; k++) step(0, 1, $urandom, $urandom, 0, 0);
    step(1, 1, $urandom, $urandom, 0, 0);
    chk("reset_beats_final", d0, 1'b0);
    for (int run = 0; run < 6; run++) begin
      step(1, 0, 0, 0, 0, 0);
      for (int k = 0; k < 22; k++)
        step($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0, $urandom, $urandom,
             $urandom_range(0, 7) == 0 ? 4'($urandom_range(1, 15)) : 4'b0000,
             $urandom_range(0, 7) == 0 ? 4'($urandom_range(1, 15)) : 4'b0000);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/tadd_checker.md
# tadd_checker

Self-checking response monitor for the `tadd` lane-parallel adder bench. It sits opposite the stimulus driver: it observes the same `en`, `a`, `b` that feed the DUT, plus the DUT outputs `y`. It holds its own cycle-accurate reference model and compares every cycle after priming. It reports per-lane mismatches, an error count, the first failing cycle, and a final `done`/`pass` verdict, so regressions grade themselves instead of relying on eyeballed `$display` logs.

## Interface
Parameters:
- `WIDTH`, 8, lane width in bits
- `LANES`, 4, number of adder lanes
- `LATENCY`, 1, DUT register stages from `a`/`b` to `y`; legal range 1..8
- `NUM_CHECKS`, 10, number of compare cycles before verdict; must be ≥ 1

Ports:
- `clock`  in  1  sole clock, rising edge
- `reset`  in  1  synchronous, active-high reset
- `en`  in  1  DUT enable, same net as the DUT
- `a`  in  LANES*WIDTH  operand A, lane i at bits [i*WIDTH +: WIDTH]
- `b`  in  LANES*WIDTH  operand B, same packing
- `y`  in  LANES*WIDTH  DUT result, same packing
- `cycles`  in  32  bench cycle counter, used only for error stamping
- `mismatch`  out  LANES  per-lane mismatch flags for the last compare
- `err_count`  out  16  count of compare cycles with any lane mismatch; saturating
- `first_err_cycle`  out  32  `cycles` value at the first mismatch
- `done`  out  1  sticky; verdict is final
- `pass`  out  1  valid when `done`; 1 iff `err_count`==0

## Operation
- Reference model:
  - `LATENCY`-stage register chain.
  - When `en`=1: stage0 <= per-lane (a+b) mod 2^WIDTH, with the carry-out discarded (two's-complement wrap), and stage k <= stage k-1.
  - When `en`=0: all stages hold.
  - Model output is stage `LATENCY`-1.
- FSM states: PRIME, CHECK, DONE.
  - PRIME:
    - A prime counter counts rising edges with `en`=1.
    - Move to CHECK on the edge where the count reaches `LATENCY`.
    - No compares happen in PRIME.
  - CHECK:
    - Every edge compares `y` against the model output, regardless of `en`. With `en`=0 both sides must hold.
    - `mismatch` <= per-lane inequality.
    - If any lane mismatches, `err_count` increments by 1 per cycle (not per lane), saturating at 16'hFFFF.
    - On the first such cycle, `first_err_cycle` <= `cycles`. It does not change on later errors.
    - A check counter increments each edge.
    - On the edge performing compare number `NUM_CHECKS`: go to DONE, `done` <= 1, `pass` <= (no mismatch on this edge and `err_count`==0 before it).
  - DONE:
    - No further compares.
    - All outputs frozen until reset.
    - `mismatch` holds its last value.
- Reset:
  - Applies at any time, including mid-CHECK or in DONE.
  - Returns the FSM to PRIME.
  - Clears the model, counters and all outputs.

## Timing
- Reset values: `mismatch`=0, `err_count`=0, `first_err_cycle`=0, `done`=0, `pass`=0, FSM=PRIME, model stages=0.
- All outputs are registered. The result of comparing `y` at edge k is visible after edge k.
- First compare happens `LATENCY` enabled edges after reset deasserts.
- With `en` held high, `done` rises `LATENCY`+`NUM_CHECKS` edges after reset release.
- `reset` and the final compare on the same edge: reset wins.

## Configuration
- `TADD_CHECKER_DISPLAY_EN` defined:
  - On every mismatching compare, print a simulation-only `$display` with `cycles`, the lane index, and the expected and actual values as signed decimals.
  - At the `done` edge, print one PASS/FAIL summary line.
- Not defined: no display statements are compiled. Port-level behaviour is identical.

## Structure
- `tadd_pkg`: default `WIDTH`/`LANES` localparams, the FSM state enum (`PRIME`, `CHECK`, `DONE`), and the saturation constant for `err_count`.
- Sub-module `tadd_ref_model`: parameterised `WIDTH`/`LANES`/`LATENCY` enabled delay line producing the expected `y`.
- `tadd_checker` contains the FSM, counters, compare, stamping and display logic.

## Test plan
- **Correct DUT.** a={7,8,28,-3}, b={3,15,1,8} (lanes 3..0), `en`=1, LATENCY=1, NUM_CHECKS=10 → expected y={10,23,29,5}; `done` 11 edges after reset release; `pass`=1, `err_count`=0.
- **Single fault.** Force y lane 2 to 24 for one cycle at `cycles`=5 → `mismatch`=4'b0100 for one cycle; then `err_count`=1, `first_err_cycle`=5, final `pass`=0.
- **Wrap-around.** a lane 0=8'hFF, b lane 0=8'h01 with a correct DUT → expected 8'h00, no mismatch; DUT reporting 8'h100-truncation-free 8'h00 passes.
- **Enable gaps.** LATENCY=2; hold `en`=0 for 3 cycles mid-CHECK while operands change → model and DUT both hold, no errors; `done` is still reached after exactly 10 compares.
- **Reset mid-run.** Inject 2 errors, assert `reset` at `cycles`=4 → all outputs return to 0; the rerun with a correct DUT ends with `pass`=1.
- **Display macro.** Build with `TADD_CHECKER_DISPLAY_EN` → exactly one mismatch line per faulty lane-cycle, plus one summary line.
